// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS32 memory-access stage: single-outstanding bus access, load alignment, LL/SC link bit.
// Define MEM_STAGE_LLSC_EN to enable the LL/SC link bit; otherwise LL acts as LW and SC as SW returning 1.
module mem_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  memop_i,
  input  logic [31:0] memAddr_i,
  input  logic [31:0] storeData_i,
  input  logic [4:0]  writeAddr_i,
  input  logic        writeEnable_i,
  input  logic [31:0] writeData_i,
  input  logic [1:0]  writeHILO_i,
  input  logic [31:0] HI_data_i,
  input  logic [31:0] LO_data_i,
  input  logic        llbitClear_i,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  output logic [4:0]  writeAddr_o,
  output logic        writeEnable_o,
  output logic [31:0] writeData_o,
  output logic [1:0]  writeHILO_o,
  output logic [31:0] HI_data_o,
  output logic [31:0] LO_data_o,
  output logic        stallreq_o
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [3:0] OP_LB  = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                         OP_LW  = 4'd5, OP_SB  = 4'd6, OP_SH = 4'd7, OP_SW  = 4'd8,
                         OP_LL  = 4'd9, OP_SC  = 4'd10;

  state_t      state;
  logic [31:0] rdata_q;
  logic        is_load, is_store, access_op, sc_fail;
  logic [3:0]  sel_c;
  logic [31:0] wdata_c, sc_result;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    sel_c    = 4'b1111;
    wdata_c  = storeData_i;
    case (memop_i)
      OP_LB, OP_LBU, OP_SB: begin
        is_load  = (memop_i != OP_SB);
        is_store = (memop_i == OP_SB);
        wdata_c  = {4{storeData_i[7:0]}};
        case (memAddr_i[1:0])
          2'b00:   sel_c = 4'b1000;
          2'b01:   sel_c = 4'b0100;
          2'b10:   sel_c = 4'b0010;
          default: sel_c = 4'b0001;
        endcase
      end
      OP_LH, OP_LHU, OP_SH: begin
        is_load  = (memop_i != OP_SH);
        is_store = (memop_i == OP_SH);
        wdata_c  = {2{storeData_i[15:0]}};
        sel_c    = memAddr_i[1] ? 4'b0011 : 4'b1100;
      end
      OP_LW, OP_LL: is_load  = 1'b1;
      OP_SW, OP_SC: is_store = 1'b1;
      default: ;
    endcase
  end

`ifdef MEM_STAGE_LLSC_EN
  logic llbit;

  // Clear has priority over the LL set so an exception between LL and SC always breaks the link.
  always_ff @(posedge clk) begin
    if (rst)
      llbit <= 1'b0;
    else if (llbitClear_i)
      llbit <= 1'b0;
    else if (state == DONE && memop_i == OP_LL)
      llbit <= 1'b1;
    else if (state == DONE && memop_i == OP_SC)
      llbit <= 1'b0;
  end

  assign sc_fail   = (memop_i == OP_SC) && !llbit;
  assign sc_result = {31'd0, llbit};
`else
  logic unused_llbit_clear;
  assign unused_llbit_clear = llbitClear_i;
  assign sc_fail   = 1'b0;
  assign sc_result = 32'd1;
`endif

  assign access_op  = (is_load || is_store) && !sc_fail;
  assign stallreq_o = access_op && (state != DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= 32'd0;
      bus_sel_o   <= 4'd0;
      bus_wdata_o <= 32'd0;
      rdata_q     <= 32'd0;
    end else begin
      case (state)
        IDLE: if (access_op) begin
          bus_req_o   <= 1'b1;
          bus_we_o    <= is_store;
          bus_addr_o  <= {memAddr_i[31:2], 2'b00};
          bus_sel_o   <= sel_c;
          bus_wdata_o <= wdata_c;
          state       <= WAIT;
        end
        WAIT: if (bus_ack_i) begin
          rdata_q   <= bus_rdata_i;
          bus_req_o <= 1'b0;
          state     <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Big-endian lanes: address offset 0 is the most significant byte.
  always_comb begin
    case (memAddr_i[1:0])
      2'b00:   ld_byte = rdata_q[31:24];
      2'b01:   ld_byte = rdata_q[23:16];
      2'b10:   ld_byte = rdata_q[15:8];
      default: ld_byte = rdata_q[7:0];
    endcase
    ld_half = memAddr_i[1] ? rdata_q[15:0] : rdata_q[31:16];
  end

  always_comb begin
    case (memop_i)
      OP_LB:        writeData_o = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:       writeData_o = {24'd0, ld_byte};
      OP_LH:        writeData_o = {{16{ld_half[15]}}, ld_half};
      OP_LHU:       writeData_o = {16'd0, ld_half};
      OP_LW, OP_LL: writeData_o = rdata_q;
      OP_SC:        writeData_o = sc_result;
      default:      writeData_o = writeData_i;
    endcase
  end

  assign writeAddr_o   = writeAddr_i;
  assign writeEnable_o = writeEnable_i;
  assign writeHILO_o   = writeHILO_i;
  assign HI_data_o     = HI_data_i;
  assign LO_data_o     = LO_data_i;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage against a transaction-level reference model.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  memop_i;
  logic [31:0] memAddr_i, storeData_i, writeData_i, HI_data_i, LO_data_i, bus_rdata_i;
  logic [4:0]  writeAddr_i;
  logic        writeEnable_i, llbitClear_i, bus_ack_i;
  logic [1:0]  writeHILO_i;
  logic        bus_req_o, bus_we_o, writeEnable_o, stallreq_o;
  logic [31:0] bus_addr_o, bus_wdata_o, writeData_o, HI_data_o, LO_data_o;
  logic [3:0]  bus_sel_o;
  logic [4:0]  writeAddr_o;
  logic [1:0]  writeHILO_o;

  int   total = 0;
  int   bad = 0;
  logic link = 1'b0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .rst(rst), .memop_i(memop_i), .memAddr_i(memAddr_i), .storeData_i(storeData_i),
    .writeAddr_i(writeAddr_i), .writeEnable_i(writeEnable_i), .writeData_i(writeData_i),
    .writeHILO_i(writeHILO_i), .HI_data_i(HI_data_i), .LO_data_i(LO_data_i),
    .llbitClear_i(llbitClear_i), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
    .bus_wdata_o(bus_wdata_o), .writeAddr_o(writeAddr_o), .writeEnable_o(writeEnable_o),
    .writeData_o(writeData_o), .writeHILO_o(writeHILO_o), .HI_data_o(HI_data_o),
    .LO_data_o(LO_data_o), .stallreq_o(stallreq_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_pass(input string tag);
    chk({tag, "_waddr"}, 32'(writeAddr_o), 32'(writeAddr_i));
    chk({tag, "_we"},    32'(writeEnable_o), 32'(writeEnable_i));
    chk({tag, "_hilo"},  32'(writeHILO_o), 32'(writeHILO_i));
    chk({tag, "_hi"},    HI_data_o, HI_data_i);
    chk({tag, "_lo"},    LO_data_o, LO_data_i);
  endtask

  task automatic chk_bus_zero(input string tag);
    chk({tag, "_req"},   32'(bus_req_o), 32'd0);
    chk({tag, "_we"},    32'(bus_we_o), 32'd0);
    chk({tag, "_addr"},  bus_addr_o, 32'd0);
    chk({tag, "_sel"},   32'(bus_sel_o), 32'd0);
    chk({tag, "_wdata"}, bus_wdata_o, 32'd0);
  endtask

  // One instruction from EX/MEM presentation through DONE; all expectations come from the op rules.
  task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                       input logic [31:0] rdata, input int waits, input logic [1:0] hilo);
    bit          is_load, is_store, sc_ok, access;
    int          size, ai, ncyc;
    logic [3:0]  e_sel;
    logic [31:0] e_wdata, e_wd, sh;
    logic [7:0]  b;
    logic [15:0] h;
    is_load  = op inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9};
    is_store = op inside {4'd6, 4'd7, 4'd8, 4'd10};
`ifdef MEM_STAGE_LLSC_EN
    sc_ok = link;
`else
    sc_ok = 1'b1;
`endif
    access = is_load || (is_store && (op != 4'd10 || sc_ok));
    size   = (op inside {4'd1, 4'd2, 4'd6}) ? 1 : (op inside {4'd3, 4'd4, 4'd7}) ? 2 : 4;
    ai     = int'(addr[1:0]);
    e_sel   = (size == 1) ? (4'b1000 >> ai) : (size == 2) ? (4'b1100 >> (2 * int'(addr[1]))) : 4'b1111;
    e_wdata = (size == 1) ? {4{rt[7:0]}} : (size == 2) ? {2{rt[15:0]}} : rt;
    sh = rdata >> (8 * (3 - ai));
    b  = sh[7:0];
    sh = rdata >> (16 * (1 - int'(addr[1])));
    h  = sh[15:0];

    @(posedge clk); #1;
    memop_i       = op;
    memAddr_i     = addr;
    storeData_i   = rt;
    writeAddr_i   = 5'($urandom);
    writeEnable_i = 1'($urandom);
    writeData_i   = $urandom;
    writeHILO_i   = hilo;
    HI_data_i     = $urandom;
    LO_data_i     = $urandom;
    llbitClear_i  = 1'b0;
    bus_ack_i     = access ? 1'b0 : 1'($urandom);
    bus_rdata_i   = $urandom;

    case (op)
      4'd1:          e_wd = 32'($signed(b));
      4'd2:          e_wd = 32'(b);
      4'd3:          e_wd = 32'($signed(h));
      4'd4:          e_wd = 32'(h);
      4'd5, 4'd9:    e_wd = rdata;
      4'd10:         e_wd = sc_ok ? 32'd1 : 32'd0;
      default:       e_wd = writeData_i;
    endcase

    ncyc = access ? waits + 3 : 1;
    for (int c = 0; c < ncyc; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        bus_ack_i   = (c == waits + 1);
        bus_rdata_i = (c == waits + 1) ? rdata : $urandom;
      end
      @(negedge clk);
      chk($sformatf("op%0d_c%0d_stall", op, c), 32'(stallreq_o), 32'(access && c < waits + 2));
      chk($sformatf("op%0d_c%0d_req", op, c), 32'(bus_req_o), 32'(access && c >= 1 && c <= waits + 1));
      if (access && c == 1) begin
        chk($sformatf("op%0d_we", op), 32'(bus_we_o), 32'(is_store));
        chk($sformatf("op%0d_addr", op), bus_addr_o, {addr[31:2], 2'b00});
        chk($sformatf("op%0d_sel", op), 32'(bus_sel_o), 32'(e_sel));
        if (is_store) chk($sformatf("op%0d_wdata", op), bus_wdata_o, e_wdata);
      end
      if (c == 0 || c == ncyc - 1) chk_pass($sformatf("op%0d_c%0d", op, c));
      if (c == ncyc - 1) chk($sformatf("op%0d_wdout", op), writeData_o, e_wd);
    end
`ifdef MEM_STAGE_LLSC_EN
    if (op == 4'd9) link = 1'b1;
    if (op == 4'd10 && sc_ok) link = 1'b0;
`endif
  endtask

  task automatic do_clear();
    @(posedge clk); #1;
    memop_i      = 4'd0;
    llbitClear_i = 1'b1;
    bus_ack_i    = 1'b0;
    @(negedge clk);
    chk("clear_stall", 32'(stallreq_o), 32'd0);
    link = 1'b0;
  endtask

  initial begin
    rst = 1'b1; memop_i = 4'd0; memAddr_i = 32'd0; storeData_i = 32'd0;
    writeAddr_i = 5'd0; writeEnable_i = 1'b0; writeData_i = 32'd0; writeHILO_i = 2'd0;
    HI_data_i = 32'd0; LO_data_i = 32'd0; llbitClear_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_bus_zero("reset");
    chk("reset_stall", 32'(stallreq_o), 32'd0);
    #1 rst = 1'b0;

    do_op(4'd5, 32'h100, $urandom, 32'hDEADBEEF, 0, 2'b00);
    do_op(4'd1, 32'h103, $urandom, 32'h000000F0, 3, 2'b00);
    do_op(4'd2, 32'h103, $urandom, 32'h000000F0, 3, 2'b00);
    do_op(4'd7, 32'h102, 32'h1234ABCD, $urandom, 0, 2'b00);
    do_op(4'd9, 32'h200, $urandom, 32'h55AA55AA, 1, 2'b00);
    do_op(4'd10, 32'h200, 32'hCAFE0001, $urandom, 0, 2'b00);
    do_op(4'd10, 32'h200, 32'hCAFE0002, $urandom, 0, 2'b00);
    do_op(4'd9, 32'h204, $urandom, 32'h11112222, 0, 2'b00);
    do_clear();
    do_op(4'd10, 32'h204, 32'hCAFE0003, $urandom, 0, 2'b00);
    do_op(4'd0, $urandom, $urandom, $urandom, 0, 2'b11);

    // Reset while the access is waiting for its ack, then a stray late ack.
    @(posedge clk); #1;
    memop_i = 4'd5; memAddr_i = 32'h300; bus_ack_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstwait_req_before", 32'(bus_req_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1; memop_i = 4'd0;
    @(posedge clk); #1;
    rst = 1'b0; bus_ack_i = 1'b1;
    @(negedge clk);
    chk_bus_zero("rstwait");
    chk("rstwait_stall", 32'(stallreq_o), 32'd0);
    @(posedge clk); #1;
    bus_ack_i = 1'b0;
    @(negedge clk);
    chk("late_ack_req", 32'(bus_req_o), 32'd0);
    link = 1'b0;

    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 7) == 0) do_clear();
      do_op(4'($urandom_range(0, 15)), $urandom, $urandom, $urandom,
            $urandom_range(0, 3), 2'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
